kpw_ram_ctrl: RTL and testbench

//  Sequencer/arbiter for the single-port pointwise-kernel weight RAM (KPW RAM, 1-cycle registered read).

---
 rtl/kpw_ram_ctrl_pkg.sv | 9 +
 rtl/kpw_ram_ctrl_addr_gen.sv | 35 +++
 rtl/kpw_ram_ctrl.sv | 85 ++++++++
 tb/tb_kpw_ram_ctrl.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kpw_ram_ctrl_pkg.sv
// Shared types and constants for the KPW weight-RAM controller.
package kpw_ram_ctrl_pkg;

  localparam int unsigned KPW_N_ELEM = 16;
  localparam int unsigned KPW_AW     = (KPW_N_ELEM > 1) ? $clog2(KPW_N_ELEM) : 1;

  typedef enum logic [1:0] {KPW_IDLE, KPW_STREAM, KPW_DRAIN} kpw_ctrl_state_t;

endpackage

// File: rtl/kpw_ram_ctrl_addr_gen.sv
// Read-burst address generator: wrap-around address counter plus remaining-length
// down-counter; last flags the final word still to be issued.
module kpw_addr_gen #(
  parameter int unsigned N_ELEM = 16,
  parameter int unsigned AW     = (N_ELEM > 1) ? $clog2(N_ELEM) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          inc,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  output logic [AW-1:0] addr,
  output logic          last
);

  logic [AW:0] remaining;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= base;
      remaining <= len;
    end else if (inc) begin
      // N_ELEM need not be a power of two, so wrap explicitly
      addr      <= (addr == AW'(N_ELEM - 1)) ? '0 : addr + 1'b1;
      remaining <= remaining - 1'b1;
    end
  end

  assign last = (remaining == (AW + 1)'(1));

endmodule

// File: rtl/kpw_ram_ctrl.sv
// Arbiter/sequencer sharing the single KPW RAM port between DMA weight writes and
// PE read bursts; reads win whenever a burst is streaming and not paused.
module kpw_ram_ctrl
  import kpw_ram_ctrl_pkg::*;
#(
  parameter int unsigned N_ELEM = KPW_N_ELEM,
  parameter int unsigned DW     = 8,
  parameter int unsigned AW     = (N_ELEM > 1) ? $clog2(N_ELEM) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dma_wr_valid,
  output logic          dma_wr_ready,
  input  logic [AW-1:0] dma_wr_addr,
  input  logic [DW-1:0] dma_wr_data,
  input  logic          rd_start,
  input  logic [AW-1:0] rd_base,
  input  logic [AW:0]   rd_len,
  input  logic          rd_pause,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic          rd_busy,
  output logic          wr_err,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_data,
  output logic          ram_write,
  input  logic [DW-1:0] ram_res
);

  kpw_ctrl_state_t state;
  logic            issue;
  logic            load;
  logic            in_range;
  logic            wr_fire;
  logic            last_word;
  logic [AW-1:0]   rd_addr;

  assign issue        = (state == KPW_STREAM) && !rd_pause;
  assign load         = (state == KPW_IDLE) && rd_start && (rd_len != '0);
  assign dma_wr_ready = !issue;
  assign in_range     = 32'(dma_wr_addr) < N_ELEM;
  assign wr_fire      = dma_wr_valid && dma_wr_ready;

  assign ram_write = wr_fire && in_range;
  assign ram_addr  = issue ? rd_addr : dma_wr_addr;
  assign ram_data  = dma_wr_data;
  assign rd_data   = ram_res;
  assign rd_busy   = (state != KPW_IDLE);

  kpw_addr_gen #(
    .N_ELEM (N_ELEM),
    .AW     (AW)
  ) u_addr_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .inc   (issue),
    .base  (rd_base),
    .len   (rd_len),
    .addr  (rd_addr),
    .last  (last_word)
  );

  // rd_valid/rd_last track the RAM's one-cycle registered read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= KPW_IDLE;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      rd_valid <= issue;
      rd_last  <= issue && last_word;
      if (wr_fire && !in_range) wr_err <= 1'b1;
      unique case (state)
        KPW_IDLE:   if (load) state <= KPW_STREAM;
        KPW_STREAM: if (issue && last_word) state <= KPW_DRAIN;
        KPW_DRAIN:  state <= KPW_IDLE;
        default:    state <= KPW_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kpw_ram_ctrl.sv
// Randomised bench for kpw_ram_ctrl: a RAM model, a reference copy of its contents and
// a word-by-word burst model predict every read, bubble and write acceptance.
module tb_kpw_ram_ctrl;

  localparam int unsigned N  = 16;
  localparam int unsigned N2 = 10;

  logic       clk;
  logic       rst_n;
  logic       dma_wr_valid;
  logic       dma_wr_ready;
  logic [3:0] dma_wr_addr;
  logic [7:0] dma_wr_data;
  logic       rd_start;
  logic [3:0] rd_base;
  logic [4:0] rd_len;
  logic       rd_pause;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_last;
  logic       rd_busy;
  logic       wr_err;
  logic [3:0] ram_addr;
  logic [7:0] ram_data;
  logic       ram_write;
  logic [7:0] ram_res;

  // Second instance with a non-power-of-two depth so out-of-range addresses exist
  logic       rd_start2;
  logic [3:0] rd_base2;
  logic [4:0] rd_len2;
  logic       rd_pause2;
  logic [7:0] ram_res2;
  logic       dma_wr_ready2;
  logic       rd_valid2;
  logic [7:0] rd_data2;
  logic       rd_last2;
  logic       rd_busy2;
  logic       wr_err2;
  logic [3:0] ram_addr2;
  logic [7:0] ram_data2;
  logic       ram_write2;

  logic [7:0] ram_mem [N];
  logic [7:0] ref_mem [N];
  logic [7:0] got_q   [$];

  int checks = 0;
  int errors = 0;

  kpw_ram_ctrl #(.N_ELEM(N), .DW(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dma_wr_valid (dma_wr_valid),
    .dma_wr_ready (dma_wr_ready),
    .dma_wr_addr  (dma_wr_addr),
    .dma_wr_data  (dma_wr_data),
    .rd_start     (rd_start),
    .rd_base      (rd_base),
    .rd_len       (rd_len),
    .rd_pause     (rd_pause),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_last      (rd_last),
    .rd_busy      (rd_busy),
    .wr_err       (wr_err),
    .ram_addr     (ram_addr),
    .ram_data     (ram_data),
    .ram_write    (ram_write),
    .ram_res      (ram_res)
  );

  kpw_ram_ctrl #(.N_ELEM(N2), .DW(8)) dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .dma_wr_valid (dma_wr_valid),
    .dma_wr_ready (dma_wr_ready2),
    .dma_wr_addr  (dma_wr_addr),
    .dma_wr_data  (dma_wr_data),
    .rd_start     (rd_start2),
    .rd_base      (rd_base2),
    .rd_len       (rd_len2),
    .rd_pause     (rd_pause2),
    .rd_valid     (rd_valid2),
    .rd_data      (rd_data2),
    .rd_last      (rd_last2),
    .rd_busy      (rd_busy2),
    .wr_err       (wr_err2),
    .ram_addr     (ram_addr2),
    .ram_data     (ram_data2),
    .ram_write    (ram_write2),
    .ram_res      (ram_res2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port RAM with one-cycle registered read
  always @(posedge clk) begin
    if (ram_write) ram_mem[ram_addr] <= ram_data;
    ram_res <= ram_mem[ram_addr];
  end

  function automatic logic [3:0] wrap_addr(input int a);
    return 4'(a % N);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (rd_valid !== 1'b0 || rd_last !== 1'b0 || rd_busy !== 1'b0 || wr_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b last=%b busy=%b err=%b, required all 0",
               rd_valid, rd_last, rd_busy, wr_err);
    end
    checks++;
    if (dma_wr_ready !== 1'b1 || wr_err2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: ready=%b err2=%b, required 1/0", dma_wr_ready, wr_err2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_len_zero();
    rd_base  = 4'($urandom);
    rd_len   = '0;
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_busy !== 1'b0 || rd_valid !== 1'b0 || dma_wr_ready !== 1'b1) begin
        errors++;
        $display("FAIL len_zero: busy=%b valid=%b ready=%b, required 0/0/1",
                 rd_busy, rd_valid, dma_wr_ready);
      end
      step();
    end
  endtask

  task automatic test_wr_err();
    logic [7:0] d;
    d = 8'($urandom);
    dma_wr_valid = 1'b1;
    dma_wr_addr  = 4'd3;
    dma_wr_data  = d;
    #1;
    checks++;
    if (ram_write !== 1'b1 || ram_write2 !== 1'b1 || ram_addr2 !== 4'd3 || ram_data2 !== d) begin
      errors++;
      $display("FAIL wr_in_range: we=%b we2=%b addr2=%0d data2=%h, required 1/1/3/%h",
               ram_write, ram_write2, ram_addr2, ram_data2, d);
    end
    step();
    ref_mem[3] = d;
    checks++;
    if (wr_err !== 1'b0 || wr_err2 !== 1'b0) begin
      errors++;
      $display("FAIL wr_err_clear: err=%b err2=%b, required 0/0", wr_err, wr_err2);
    end
    d = 8'($urandom);
    dma_wr_addr = 4'd12;
    dma_wr_data = d;
    #1;
    checks++;
    if (ram_write !== 1'b1 || ram_write2 !== 1'b0 || dma_wr_ready2 !== 1'b1) begin
      errors++;
      $display("FAIL wr_out_of_range: we=%b we2=%b ready2=%b, required 1/0/1",
               ram_write, ram_write2, dma_wr_ready2);
    end
    step();
    ref_mem[12] = d;
    dma_wr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr_err2 !== 1'b1 || wr_err !== 1'b0) begin
        errors++;
        $display("FAIL wr_err_sticky: err2=%b err=%b, required 1/0", wr_err2, wr_err);
      end
      step();
    end
    checks++;
    if (rd_valid2 !== 1'b0 || rd_last2 !== 1'b0 || rd_busy2 !== 1'b0 || rd_data2 !== 8'h00) begin
      errors++;
      $display("FAIL dut2_idle: valid=%b last=%b busy=%b data=%h, required 0/0/0/00",
               rd_valid2, rd_last2, rd_busy2, rd_data2);
    end
  endtask

  task automatic test_fill();
    int nwr;
    nwr = 0;
    for (int i = 0; i < 16; i++) begin
      dma_wr_valid = 1'b1;
      dma_wr_addr  = 4'(i);
      dma_wr_data  = 8'(8'h10 + i);
      #1;
      checks++;
      if (dma_wr_ready !== 1'b1 || ram_write !== 1'b1) begin
        errors++;
        $display("FAIL fill_write[%0d]: ready=%b we=%b, required 1/1", i, dma_wr_ready, ram_write);
      end
      if (ram_write === 1'b1) nwr++;
      step();
      ref_mem[i] = 8'(8'h10 + i);
    end
    dma_wr_valid = 1'b0;
    checks++;
    if (nwr != 16) begin
      errors++;
      $display("FAIL fill_count: writes=%0d, required 16", nwr);
    end
  endtask

  task automatic run_burst(input int base, input int len, input int pause_pct,
                           input int pause_from, input int pause_num, input bit bubble_wr,
                           input int wr_fixed, input int restart_at,
                           output int bubbles, output int wr_acc);
    int         n;
    int         cyc;
    int         words;
    bit         ev, el, nv, nl;
    logic [7:0] ed, nd;
    bit         pause, issue, wr_try;
    logic [3:0] wa;
    logic [7:0] wd;
    n = 0; cyc = 0; words = 0;
    ev = 1'b0; el = 1'b0; ed = '0;
    bubbles = 0; wr_acc = 0;
    got_q.delete();
    rd_base  = 4'(base);
    rd_len   = 5'(len);
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    while ((n < len || ev) && cyc < 100) begin
      checks++;
      if (rd_valid !== ev || rd_busy !== 1'b1) begin
        errors++;
        $display("FAIL burst_valid cyc%0d: valid=%b busy=%b, required %b/1",
                 cyc, rd_valid, rd_busy, ev);
      end
      checks++;
      if (ev && (rd_data !== ed || rd_last !== el)) begin
        errors++;
        $display("FAIL burst_data cyc%0d: data=%h last=%b, required %h/%b",
                 cyc, rd_data, rd_last, ed, el);
      end else if (!ev && rd_last !== 1'b0) begin
        errors++;
        $display("FAIL burst_last cyc%0d: last=%b, required 0", cyc, rd_last);
      end
      if (ev && rd_valid === 1'b1) begin
        got_q.push_back(rd_data);
        words++;
      end
      pause = (n < len) && ((cyc >= pause_from && cyc < pause_from + pause_num) ||
                            ($urandom_range(99) < 32'(pause_pct)));
      issue = (n < len) && !pause;
      if (n < len && pause) bubbles++;
      wr_try = bubble_wr && (n < len) && (pause || $urandom_range(1) == 1);
      wa     = (wr_fixed >= 0) ? 4'(wr_fixed) : 4'($urandom);
      wd     = 8'($urandom);
      rd_pause     = pause;
      rd_start     = (cyc == restart_at);
      rd_base      = 4'($urandom);
      rd_len       = 5'($urandom_range(1, 16));
      dma_wr_valid = wr_try;
      dma_wr_addr  = wa;
      dma_wr_data  = wd;
      #1;
      checks++;
      if (dma_wr_ready !== !issue || ram_write !== (wr_try && !issue)) begin
        errors++;
        $display("FAIL arbitration cyc%0d: ready=%b we=%b, required %b/%b",
                 cyc, dma_wr_ready, ram_write, !issue, wr_try && !issue);
      end
      if (issue) begin
        checks++;
        if (ram_addr !== wrap_addr(base + n)) begin
          errors++;
          $display("FAIL read_addr cyc%0d: addr=%0d, required %0d",
                   cyc, ram_addr, wrap_addr(base + n));
        end
      end
      nv = issue;
      nl = issue && (n == len - 1);
      nd = issue ? ref_mem[wrap_addr(base + n)] : 8'h00;
      if (issue) n++;
      if (wr_try && !issue) wr_acc++;
      step();
      if (wr_try && !issue) ref_mem[wa] = wd;
      ev = nv; el = nl; ed = nd;
      cyc++;
    end
    rd_pause     = 1'b0;
    rd_start     = 1'b0;
    dma_wr_valid = 1'b0;
    #1;
    checks++;
    if (cyc >= 100 || rd_busy !== 1'b0 || rd_valid !== 1'b0 || words != len) begin
      errors++;
      $display("FAIL burst_end: cycles=%0d busy=%b valid=%b words=%0d, required <100/0/0/%0d",
               cyc, rd_busy, rd_valid, words, len);
    end
  endtask

  task automatic test_full_burst();
    int b, w;
    run_burst(0, 16, 0, -1, 0, 1'b0, -1, -1, b, w);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== 8'(8'h10 + i)) begin
        errors++;
        $display("FAIL full_burst_word[%0d]: got %h, required %h", i,
                 (i < got_q.size()) ? got_q[i] : 8'hxx, 8'(8'h10 + i));
      end
    end
  endtask

  task automatic test_wrap();
    int b, w;
    run_burst(14, 4, 0, -1, 0, 1'b0, -1, -1, b, w);
    checks++;
    if (got_q.size() != 4 || got_q[0] !== ref_mem[14] || got_q[1] !== ref_mem[15] ||
        got_q[2] !== ref_mem[0] || got_q[3] !== ref_mem[1]) begin
      errors++;
      $display("FAIL wrap_order: got %0d words, first %h, required 4 words from 14,15,0,1",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
  endtask

  task automatic test_pause_writes();
    int b, w;
    run_burst(0, 8, 0, 3, 2, 1'b1, 5, -1, b, w);
    checks++;
    if (b != 2 || w != 2) begin
      errors++;
      $display("FAIL pause_counts: bubbles=%0d writes=%0d, required 2/2", b, w);
    end
  endtask

  task automatic test_restart_ignored();
    int b, w;
    run_burst(2, 10, 0, -1, 0, 1'b0, -1, 3, b, w);
  endtask

  task automatic test_random_bursts();
    int b, w;
    for (int i = 0; i < 8; i++) begin
      run_burst(int'($urandom_range(15)), int'($urandom_range(1, 16)), 30, -1, 0, 1'b1,
                -1, -1, b, w);
      step();
    end
  endtask

  task automatic test_reset_mid_burst();
    rd_base  = 4'd0;
    rd_len   = 5'd8;
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    step();
    checks++;
    if (rd_valid !== 1'b1 || wr_err2 !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: valid=%b err2=%b, required 1/1", rd_valid, wr_err2);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rd_valid !== 1'b0 || rd_last !== 1'b0 || rd_busy !== 1'b0 || wr_err2 !== 1'b0 ||
        dma_wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: valid=%b last=%b busy=%b err2=%b ready=%b, required 0/0/0/0/1",
               rd_valid, rd_last, rd_busy, wr_err2, dma_wr_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (rd_valid !== 1'b0 || rd_busy !== 1'b0) begin
        errors++;
        $display("FAIL post_reset cyc%0d: valid=%b busy=%b, required 0/0", i, rd_valid, rd_busy);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    dma_wr_valid = 1'b0; dma_wr_addr = '0; dma_wr_data = '0;
    rd_start = 1'b0; rd_base = '0; rd_len = '0; rd_pause = 1'b0;
    rd_start2 = 1'b0; rd_base2 = '0; rd_len2 = '0; rd_pause2 = 1'b0; ram_res2 = '0;
    test_reset();
    test_len_zero();
    test_wr_err();
    test_fill();
    test_full_burst();
    test_wrap();
    test_pause_writes();
    test_restart_ignored();
    test_random_bursts();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
